// File: rtl/fp_hazard_scoreboard_pkg.sv
// fp_hazard_scoreboard_pkg: shared widths, FSM states, hazard cause encoding and source-match helper
package fp_hazard_scoreboard_pkg;
  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
  localparam int FP_LAT_DEF = 4;
  localparam int CNT_BITS = 4;
  typedef enum logic {IDLE, BUSY} fp_state_e;
  typedef enum logic [2:0] {HZ_NONE, HZ_LOAD_USE, HZ_FP_RAW, HZ_FP_WAW, HZ_FP_STRUCT} hazard_e;
  function automatic logic src_match(input logic uses_rs, input logic [REG_W-1:0] rs,
                                     input logic uses_rt, input logic [REG_W-1:0] rt,
                                     input logic [REG_W-1:0] r);
    return (r != REG_ZERO) && ((uses_rs && rs == r) || (uses_rt && rt == r));
  endfunction
endpackage

// File: rtl/fp_hazard_scoreboard_fp_latency_tracker.sv
// fp_latency_tracker: countdown for the single in-flight FP op, pulses done with its destination
module fp_latency_tracker
  import fp_hazard_scoreboard_pkg::*;
#(
  parameter int FP_LAT = FP_LAT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue,
  input  logic [REG_W-1:0] issue_rd,
  input  logic             issue_write,
  output logic             busy,
  output logic             done,
  output logic [REG_W-1:0] done_rd,
  output logic [REG_W-1:0] pend_rd
);
  fp_state_e state, state_n;
  logic [CNT_BITS-1:0] cnt, cnt_n;
  logic [REG_W-1:0] pend_rd_n;
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      pend_rd <= REG_ZERO;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      pend_rd <= pend_rd_n;
    end
  end
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    pend_rd_n = pend_rd;
    if (state == IDLE) begin
      if (issue) begin
        state_n   = BUSY;
        cnt_n     = CNT_BITS'(FP_LAT - 1);
        pend_rd_n = issue_write ? issue_rd : REG_ZERO;
      end
    end else if (cnt == '0) state_n = IDLE;
    else cnt_n = cnt - 1'b1;
  end
  assign busy    = state == BUSY;
  assign done    = busy && cnt == '0 && !reset;
  assign done_rd = done ? pend_rd : REG_ZERO;
endmodule

// File: rtl/fp_hazard_scoreboard.sv
// fp_hazard_scoreboard: ID-stage interlock for load-use, FP RAW/WAW and FPU structural hazards
module fp_hazard_scoreboard
  import fp_hazard_scoreboard_pkg::*;
#(
  parameter int FP_LAT = FP_LAT_DEF,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [4:0]       id_rd,
  input  logic             id_reg_write,
  input  logic             id_is_fp,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  output logic             stall,
  output logic             fp_issue,
  output logic             fp_busy,
  output logic             fp_done,
  output logic [4:0]       fp_done_rd,
  output logic [CNT_W-1:0] stall_count
);
  logic [REG_W-1:0] pend_rd;
  logic load_use, raw, waw, structural;
  assign load_use   = ex_mem_read && src_match(id_uses_rs, id_rs, id_uses_rt, id_rt, ex_rt);
  assign raw        = fp_busy && src_match(id_uses_rs, id_rs, id_uses_rt, id_rt, pend_rd);
  assign waw        = fp_busy && id_reg_write && id_rd != REG_ZERO && id_rd == pend_rd;
  assign structural = fp_busy && id_is_fp;
  assign stall      = id_valid && !reset && (load_use || raw || waw || structural);
  assign fp_issue   = id_valid && id_is_fp && !stall;
  fp_latency_tracker #(.FP_LAT(FP_LAT)) u_tracker (
    .clk        (clk),
    .reset      (reset),
    .issue      (fp_issue),
    .issue_rd   (id_rd),
    .issue_write(id_reg_write),
    .busy       (fp_busy),
    .done       (fp_done),
    .done_rd    (fp_done_rd),
    .pend_rd    (pend_rd)
  );
  always_ff @(posedge clk) begin
    if (reset) stall_count <= '0;
    else if (stall && !(&stall_count)) stall_count <= stall_count + 1'b1;
  end
endmodule

// File: tb/tb_fp_hazard_scoreboard.sv
// tb_fp_hazard_scoreboard: directed + random stimulus, expected outputs queued from a cycle-level model
module tb_fp_hazard_scoreboard;
  import fp_hazard_scoreboard_pkg::*;
  localparam int LAT = 4;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  typedef struct {
    bit rst, v, urs, urt, rw, fp, mr;
    logic [4:0] rs, rt, rd, ert;
  } stim_t;
  typedef struct {
    logic stall, iss, busy, done;
    logic [4:0] drd;
    logic [CW-1:0] cnt;
  } exp_t;

  logic clk = 0, reset = 1, id_valid = 0, id_uses_rs = 0, id_uses_rt = 0;
  logic id_reg_write = 0, id_is_fp = 0, ex_mem_read = 0;
  logic [4:0] id_rs = 0, id_rt = 0, id_rd = 0, ex_rt = 0;
  logic stall, fp_issue, fp_busy, fp_done;
  logic [4:0] fp_done_rd;
  logic [CW-1:0] stall_count;

  fp_hazard_scoreboard #(.FP_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_fp(id_is_fp), .ex_mem_read(ex_mem_read),
    .ex_rt(ex_rt), .stall(stall), .fp_issue(fp_issue), .fp_busy(fp_busy),
    .fp_done(fp_done), .fp_done_rd(fp_done_rd), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int total = 0, bad = 0;
  int remaining = 0;
  int m_pend = 0;
  int m_cnt = 0;
  int cov[5] = '{default: 0};

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("stall", int'(stall), int'(e.stall));
      check("fp_issue", int'(fp_issue), int'(e.iss));
      check("fp_busy", int'(fp_busy), int'(e.busy));
      check("fp_done", int'(fp_done), int'(e.done));
      check("fp_done_rd", int'(fp_done_rd), int'(e.drd));
      check("stall_count", int'(stall_count), int'(e.cnt));
    end
  end

  function automatic bit reads(input stim_t s, input int r);
    return r != 0 && ((s.urs && int'(s.rs) == r) || (s.urt && int'(s.rt) == r));
  endfunction

  task automatic step(input stim_t s, input bit push);
    exp_t e;
    bit pending, lu, raw, waw, st;
    hazard_e cause;
    @(posedge clk);
    #1;
    reset = s.rst; id_valid = s.v; id_uses_rs = s.urs; id_uses_rt = s.urt;
    id_reg_write = s.rw; id_is_fp = s.fp; ex_mem_read = s.mr;
    id_rs = s.rs; id_rt = s.rt; id_rd = s.rd; ex_rt = s.ert;
    pending = remaining > 0;
    lu  = s.mr && reads(s, int'(s.ert));
    raw = pending && reads(s, m_pend);
    waw = pending && s.rw && s.rd != 0 && int'(s.rd) == m_pend;
    st  = pending && s.fp;
    cause = lu ? HZ_LOAD_USE : raw ? HZ_FP_RAW : waw ? HZ_FP_WAW : st ? HZ_FP_STRUCT : HZ_NONE;
    if (s.v) cov[int'(cause)]++;
    e.stall = s.v && !s.rst && (lu || raw || waw || st);
    e.iss   = s.v && s.fp && !e.stall;
    e.busy  = pending;
    e.done  = pending && remaining == 1 && !s.rst;
    e.drd   = e.done ? 5'(m_pend) : 5'd0;
    e.cnt   = CW'(m_cnt);
    if (push) q.push_back(e);
    if (s.rst) begin
      remaining = 0; m_pend = 0; m_cnt = 0;
    end else begin
      if (e.stall && m_cnt < SAT) m_cnt++;
      if (pending) remaining--;
      if (e.iss) begin
        remaining = LAT;
        m_pend = s.rw ? int'(s.rd) : 0;
      end
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  initial begin
    stim_t s, fpop;
    s = idle(); s.rst = 1;
    step(s, 0);
    step(s, 1);
    s = idle(); s.v = 1; s.urs = 1; s.rs = 8; s.mr = 1; s.ert = 8;
    step(s, 1);
    s.mr = 0;
    step(s, 1);
    fpop = idle(); fpop.v = 1; fpop.fp = 1; fpop.rw = 1; fpop.rd = 5;
    step(fpop, 1);
    s = idle(); s.v = 1; s.urt = 1; s.rt = 5;
    repeat (5) step(s, 1);
    fpop.rd = 6;
    step(fpop, 1);
    fpop.rd = 7;
    repeat (5) step(fpop, 1);
    repeat (5) step(idle(), 1);
    fpop.rd = 0;
    step(fpop, 1);
    s = idle(); s.v = 1; s.urs = 1; s.rs = 0; s.rw = 1; s.rd = 0;
    step(s, 1);
    s.mr = 1; s.ert = 0;
    step(s, 1);
    repeat (4) step(idle(), 1);
    fpop.rd = 9;
    step(fpop, 1);
    step(idle(), 1);
    s = idle(); s.rst = 1;
    step(s, 1);
    repeat (6) step(idle(), 1);
    s = idle(); s.v = 1; s.urs = 1; s.rs = 3; s.mr = 1; s.ert = 3;
    repeat (20) step(s, 1);
    step(idle(), 1);
    for (int i = 0; i < 3000; i++) begin
      s.rst = $urandom_range(0, 63) == 0;
      s.v   = $urandom_range(0, 3) != 0;
      s.urs = 1'($urandom); s.urt = 1'($urandom); s.rw = 1'($urandom);
      s.fp  = $urandom_range(0, 2) == 0; s.mr = $urandom_range(0, 3) == 0;
      s.rs  = 5'($urandom_range(0, 3)); s.rt = 5'($urandom_range(0, 3));
      s.rd  = 5'($urandom_range(0, 3)); s.ert = 5'($urandom_range(0, 3));
      step(s, 1);
    end
    step(idle(), 1);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (q.size() > 0) begin
      bad++;
      $display("FAIL drain: got %0d entries left expected 0", q.size());
    end
    $display("coverage none=%0d load_use=%0d raw=%0d waw=%0d struct=%0d",
             cov[0], cov[1], cov[2], cov[3], cov[4]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
